// File: rtl/rv_decode_stage.sv
// RV32I/RV64I (+ optional M) instruction decode stage with a two-entry skid
// buffer. Decode is combinational from the incoming instruction and is
// captured on accept; the main entry drives the outputs, and the skid entry
// absorbs one extra beat so in_ready can be a pure register output.
module rv_decode_stage #(
   parameter int XLEN          = 32,
   parameter bit ENABLE_M      = 1'b0,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_inst,
   input  logic [XLEN-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [6:0]               out_opcode,
   output logic [4:0]               out_rd,
   output logic [4:0]               out_rs1,
   output logic [4:0]               out_rs2,
   output logic [2:0]               out_funct3,
   output logic [6:0]               out_funct7,
   output logic [11:0]              out_funct12,
   output logic [XLEN-1:0]          out_imm,
   output logic                     out_decode_error,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("rv_decode_stage: XLEN must be 32 or 64");
      end
   endgenerate

   localparam logic [6:0] OPC_OP        = 7'h33;
   localparam logic [6:0] OPC_OP_IMM    = 7'h13;
   localparam logic [6:0] OPC_LOAD      = 7'h03;
   localparam logic [6:0] OPC_STORE     = 7'h23;
   localparam logic [6:0] OPC_LUI       = 7'h37;
   localparam logic [6:0] OPC_AUIPC     = 7'h17;
   localparam logic [6:0] OPC_JAL       = 7'h6F;
   localparam logic [6:0] OPC_JALR      = 7'h67;
   localparam logic [6:0] OPC_BRANCH    = 7'h63;
   localparam logic [6:0] OPC_SYSTEM    = 7'h73;
   localparam logic [6:0] OPC_MISC_MEM  = 7'h0F;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
   localparam logic [6:0] OPC_OP_32     = 7'h3B;

   localparam bit IS_RV64 = (XLEN == 64);
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

   // Buffered beat: the raw instruction is kept so the field outputs are
   // simple slices; immediate and legality are captured already decoded.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic [XLEN-1:0] imm;
      logic            err;
   } beat_t;

   logic [6:0]  dec_opcode;
   logic [2:0]  dec_funct3;
   logic [6:0]  dec_funct7;
   logic [11:0] dec_funct12;
   logic [4:0]  dec_rd;
   logic [4:0]  dec_rs1;
   logic [63:0] dec_imm_wide;
   logic        dec_error;
   logic        op_funct7_ok;
   logic        op32_ok;

   beat_t dec_beat;
   beat_t main_beat;
   beat_t skid_beat;
   logic  main_valid;
   logic  skid_valid;
   logic  accept;
   logic  emit;

   logic [ERR_CNT_WIDTH-1:0] err_q;

   assign dec_opcode  = in_inst[6:0];
   assign dec_funct3  = in_inst[14:12];
   assign dec_funct7  = in_inst[31:25];
   assign dec_funct12 = in_inst[31:20];
   assign dec_rd      = in_inst[11:7];
   assign dec_rs1     = in_inst[19:15];

   // Immediate assembly, built 64 bits wide and trimmed to XLEN afterwards.
   always_comb begin
      dec_imm_wide = {{52{in_inst[31]}}, in_inst[31:20]};
      case (dec_opcode)
         OPC_STORE:          dec_imm_wide = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         OPC_LUI, OPC_AUIPC: dec_imm_wide = {{32{in_inst[31]}}, in_inst[31:12], 12'h000};
         OPC_JAL:            dec_imm_wide = {{44{in_inst[31]}}, in_inst[19:12], in_inst[20],
                                             in_inst[30:21], 1'b0};
         OPC_BRANCH:         dec_imm_wide = {{52{in_inst[31]}}, in_inst[7], in_inst[30:25],
                                             in_inst[11:8], 1'b0};
         default:            ;
      endcase
   end

   // Register-register funct7/funct3 legality shared by OP and OP-32.
   always_comb begin
      op_funct7_ok = (dec_funct7 == 7'h00)
                  || (dec_funct7 == 7'h20 && (dec_funct3 == 3'd0 || dec_funct3 == 3'd5))
                  || (ENABLE_M && dec_funct7 == 7'h01);
      if (ENABLE_M && dec_funct7 == 7'h01) begin
         op32_ok = (dec_funct3 == 3'd0) || (dec_funct3 >= 3'd4);
      end else begin
         op32_ok = (dec_funct3 == 3'd0 || dec_funct3 == 3'd1 || dec_funct3 == 3'd5)
                && op_funct7_ok;
      end
   end

   // Full legality check of the incoming instruction.
   always_comb begin
      dec_error = (in_inst[1:0] != 2'b11);
      case (dec_opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: ;
         OPC_OP: begin
            if (!op_funct7_ok) dec_error = 1'b1;
         end
         OPC_OP_IMM: begin
            if (dec_funct3 == 3'd1) begin
               if (IS_RV64 ? (in_inst[31:26] != 6'h00) : (dec_funct7 != 7'h00))
                  dec_error = 1'b1;
            end else if (dec_funct3 == 3'd5) begin
               if (IS_RV64 ? !(in_inst[31:26] == 6'h00 || in_inst[31:26] == 6'h10)
                           : !(dec_funct7 == 7'h00 || dec_funct7 == 7'h20))
                  dec_error = 1'b1;
            end
         end
         OPC_LOAD: begin
            if (IS_RV64 ? (dec_funct3 == 3'd7)
                        : (dec_funct3 == 3'd3 || dec_funct3 == 3'd6 || dec_funct3 == 3'd7))
               dec_error = 1'b1;
         end
         OPC_STORE: begin
            if (IS_RV64 ? (dec_funct3 > 3'd3) : (dec_funct3 > 3'd2)) dec_error = 1'b1;
         end
         OPC_BRANCH: begin
            if (dec_funct3 == 3'd2 || dec_funct3 == 3'd3) dec_error = 1'b1;
         end
         OPC_JALR: begin
            if (dec_funct3 != 3'd0) dec_error = 1'b1;
         end
         OPC_MISC_MEM: begin
            if (dec_funct3 > 3'd1) dec_error = 1'b1;
         end
         OPC_SYSTEM: begin
            if (dec_funct3 == 3'd4) begin
               dec_error = 1'b1;
            end else if (dec_funct3 == 3'd0) begin
               if (!(dec_funct12 == 12'h000 || dec_funct12 == 12'h001)
                   || dec_rd != 5'd0 || dec_rs1 != 5'd0)
                  dec_error = 1'b1;
            end
         end
         OPC_OP_IMM_32: begin
            if (!IS_RV64) begin
               dec_error = 1'b1;
            end else if (dec_funct3 == 3'd1) begin
               if (dec_funct7 != 7'h00) dec_error = 1'b1;
            end else if (dec_funct3 == 3'd5) begin
               if (!(dec_funct7 == 7'h00 || dec_funct7 == 7'h20)) dec_error = 1'b1;
            end else if (dec_funct3 != 3'd0) begin
               dec_error = 1'b1;
            end
         end
         OPC_OP_32: begin
            if (!IS_RV64 || !op32_ok) dec_error = 1'b1;
         end
         default: dec_error = 1'b1;
      endcase
   end

   assign dec_beat.pc   = in_pc;
   assign dec_beat.inst = in_inst;
   assign dec_beat.imm  = dec_imm_wide[XLEN-1:0];
   assign dec_beat.err  = dec_error;

   assign in_ready = ~skid_valid;
   assign accept   = in_valid & ~skid_valid;
   assign emit     = main_valid & out_ready;

   // Skid buffer: rst beats flush, flush beats any accept or emit. The skid
   // entry only fills when the main entry is occupied and not draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (emit) begin
         if (skid_valid) begin
            main_beat  <= skid_beat;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_beat <= dec_beat;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         if (main_valid) begin
            skid_beat  <= dec_beat;
            skid_valid <= 1'b1;
         end else begin
            main_beat  <= dec_beat;
            main_valid <= 1'b1;
         end
      end
   end

   // Saturating count of illegal beats actually handed downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= '0;
      end else if (!flush && emit && main_beat.err && err_q != '1) begin
         err_q <= err_q + ERR_ONE;
      end
   end

   assign out_valid        = main_valid;
   assign out_pc           = main_beat.pc;
   assign out_opcode       = main_beat.inst[6:0];
   assign out_rd           = main_beat.inst[11:7];
   assign out_rs1          = main_beat.inst[19:15];
   assign out_rs2          = main_beat.inst[24:20];
   assign out_funct3       = main_beat.inst[14:12];
   assign out_funct7       = main_beat.inst[31:25];
   assign out_funct12      = main_beat.inst[31:20];
   assign out_imm          = main_beat.imm;
   assign out_decode_error = main_beat.err;
   assign err_count        = err_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage. Two instances share one stimulus
// stream: "a" is RV32 without M and a 2-bit error counter, "b" is RV64 with
// M and a 16-bit counter, so each vector exercises both configurations.
module tb_rv_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc;

   logic        a_in_ready, a_out_valid, a_out_decode_error;
   logic [31:0] a_out_pc, a_out_imm;
   logic [6:0]  a_out_opcode, a_out_funct7;
   logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
   logic [2:0]  a_out_funct3;
   logic [11:0] a_out_funct12;
   logic [1:0]  a_err_count;

   logic        b_in_ready, b_out_valid, b_out_decode_error;
   logic [63:0] b_out_pc, b_out_imm;
   logic [6:0]  b_out_opcode, b_out_funct7;
   logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
   logic [2:0]  b_out_funct3;
   logic [11:0] b_out_funct12;
   logic [15:0] b_err_count;

   int tests_run    = 0;
   int tests_failed = 0;

   // Legality vectors: instruction, expected error for RV32 (no M), for RV64 (+M)
   logic [31:0] vec_inst [0:10] = '{32'h02009093, 32'h4000D093, 32'h00000073, 32'h00200073,
                                    32'h002080BB, 32'h0010B023, 32'h0000A063, 32'h00001067,
                                    32'h0200D0BB, 32'h0200A0BB, 32'h40001033};
   logic        vec_a_err [0:10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic        vec_b_err [0:10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

   always #5 clk = ~clk;

   rv_decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ERR_CNT_WIDTH(2)) dut_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
      .out_opcode(a_out_opcode), .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
      .out_funct3(a_out_funct3), .out_funct7(a_out_funct7), .out_funct12(a_out_funct12),
      .out_imm(a_out_imm), .out_decode_error(a_out_decode_error), .err_count(a_err_count)
   );

   rv_decode_stage #(.XLEN(64), .ENABLE_M(1'b1), .ERR_CNT_WIDTH(16)) dut_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
      .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
      .out_funct3(b_out_funct3), .out_funct7(b_out_funct7), .out_funct12(b_out_funct12),
      .out_imm(b_out_imm), .out_decode_error(b_out_decode_error), .err_count(b_err_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_inst = 32'h0; in_pc = 64'h0;
      step();
      step();
      rst = 1'b0;
      tests_run++;
      if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_out_valid got a=%b b=%b want 0", a_out_valid, b_out_valid);
      end
      tests_run++;
      if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL reset_in_ready got a=%b b=%b want 1", a_in_ready, b_in_ready);
      end
      tests_run++;
      if (a_err_count !== 2'd0 || b_err_count !== 16'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_err_count got a=%0d b=%0d want 0", a_err_count, b_err_count);
      end
   endtask

   task automatic test_addi();
      in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 64'h100; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      tests_run++;
      if (a_out_valid !== 1'b1 || a_out_opcode !== 7'h13 || a_out_rd !== 5'd1 ||
          a_out_rs1 !== 5'd0 || a_out_funct12 !== 12'hFFF || a_out_pc !== 32'h100) begin
         tests_failed++;
         $display("[TB] FAIL addi_fields_a got v=%b op=%h rd=%0d rs1=%0d f12=%h pc=%h want 1/13/1/0/fff/100",
                  a_out_valid, a_out_opcode, a_out_rd, a_out_rs1, a_out_funct12, a_out_pc);
      end
      tests_run++;
      if (a_out_imm !== 32'hFFFFFFFF || a_out_decode_error !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL addi_imm_a got imm=%h err=%b want ffffffff/0", a_out_imm, a_out_decode_error);
      end
      tests_run++;
      if (b_out_imm !== 64'hFFFFFFFFFFFFFFFF || b_out_decode_error !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL addi_imm_b got imm=%h err=%b want ffffffffffffffff/0", b_out_imm, b_out_decode_error);
      end
      tests_run++;
      if (b_out_opcode !== 7'h13 || b_out_rd !== 5'd1 || b_out_rs1 !== 5'd0 || b_out_rs2 !== 5'd31 ||
          b_out_funct3 !== 3'd0 || b_out_funct7 !== 7'h7F || b_out_funct12 !== 12'hFFF) begin
         tests_failed++;
         $display("[TB] FAIL addi_fields_b got op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h f12=%h want 13/1/0/31/0/7f/fff",
                  b_out_opcode, b_out_rd, b_out_rs1, b_out_rs2, b_out_funct3, b_out_funct7, b_out_funct12);
      end
      step();
      tests_run++;
      if (a_out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL addi_drain got out_valid=%b want 0", a_out_valid);
      end
   endtask

   task automatic test_immediates();
      out_ready = 1'b1; in_valid = 1'b1;
      in_inst = 32'hFFDFF06F; in_pc = 64'h200;
      step();
      tests_run++;
      if (a_out_imm !== 32'hFFFFFFFC || b_out_imm !== 64'hFFFFFFFFFFFFFFFC || b_out_decode_error !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL jal_imm got a=%h b=%h err=%b want fffffffc/fffffffffffffffc/0",
                  a_out_imm, b_out_imm, b_out_decode_error);
      end
      in_inst = 32'h800000B7; in_pc = 64'h204;
      step();
      tests_run++;
      if (a_out_imm !== 32'h80000000 || b_out_imm !== 64'hFFFFFFFF80000000 || a_out_pc !== 32'h204) begin
         tests_failed++;
         $display("[TB] FAIL lui_imm got a=%h b=%h pc=%h want 80000000/ffffffff80000000/204",
                  a_out_imm, b_out_imm, a_out_pc);
      end
      in_inst = 32'hFE000FE3; in_pc = 64'h208;
      step();
      tests_run++;
      if (a_out_imm !== 32'hFFFFFFFE || b_out_imm !== 64'hFFFFFFFFFFFFFFFE || a_out_decode_error !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL beq_imm got a=%h b=%h err=%b want fffffffe/fffffffffffffffe/0",
                  a_out_imm, b_out_imm, a_out_decode_error);
      end
      in_inst = 32'hFE112C23; in_pc = 64'h20C;
      step();
      in_valid = 1'b0;
      tests_run++;
      if (a_out_imm !== 32'hFFFFFFF8 || a_out_rs2 !== 5'd1 || a_out_rs1 !== 5'd2 ||
          a_out_funct3 !== 3'd2 || a_out_funct7 !== 7'h7F || a_out_decode_error !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL sw_fields got imm=%h rs2=%0d rs1=%0d f3=%0d f7=%h err=%b want fffffff8/1/2/2/7f/0",
                  a_out_imm, a_out_rs2, a_out_rs1, a_out_funct3, a_out_funct7, a_out_decode_error);
      end
      step();
   endtask

   task automatic test_legality_basic();
      out_ready = 1'b1; in_valid = 1'b1;
      in_inst = 32'h0000B083; in_pc = 64'h300;
      step();
      tests_run++;
      if (a_out_decode_error !== 1'b1 || b_out_decode_error !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ld_error got a=%b b=%b want 1/0", a_out_decode_error, b_out_decode_error);
      end
      in_inst = 32'h022081B3; in_pc = 64'h304;
      step();
      tests_run++;
      if (a_out_decode_error !== 1'b1 || b_out_decode_error !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL mul_error got a=%b b=%b want 1/0", a_out_decode_error, b_out_decode_error);
      end
      tests_run++;
      if (a_err_count !== 2'd1 || b_err_count !== 16'd0) begin
         tests_failed++;
         $display("[TB] FAIL ld_err_count got a=%0d b=%0d want 1/0", a_err_count, b_err_count);
      end
      in_inst = 32'h00000000; in_pc = 64'h308;
      step();
      in_valid = 1'b0;
      tests_run++;
      if (a_out_decode_error !== 1'b1 || b_out_decode_error !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL zero_error got a=%b b=%b want 1/1", a_out_decode_error, b_out_decode_error);
      end
      step();
      tests_run++;
      if (a_err_count !== 2'd3 || b_err_count !== 16'd1) begin
         tests_failed++;
         $display("[TB] FAIL basic_err_count got a=%0d b=%0d want 3/1", a_err_count, b_err_count);
      end
   endtask

   task automatic test_legality_table();
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         in_valid = 1'b1; in_inst = vec_inst[i]; in_pc = 64'h400 + 64'(4 * i);
         step();
         tests_run++;
         if (a_out_decode_error !== vec_a_err[i] || b_out_decode_error !== vec_b_err[i]) begin
            tests_failed++;
            $display("[TB] FAIL legality[%0d] inst=%h got a=%b b=%b want a=%b b=%b", i, vec_inst[i],
                     a_out_decode_error, b_out_decode_error, vec_a_err[i], vec_b_err[i]);
         end
      end
      in_valid = 1'b0;
      step();
      tests_run++;
      if (a_err_count !== 2'd3 || b_err_count !== 16'd6) begin
         tests_failed++;
         $display("[TB] FAIL table_err_count got a=%0d b=%0d want 3/6", a_err_count, b_err_count);
      end
   endtask

   task automatic test_backpressure();
      int          accepted;
      int          delivered;
      logic        rdy;
      logic [31:0] got_pc [4];
      accepted = 0; delivered = 0;
      out_ready = 1'b0; in_inst = 32'h00000013;
      for (int c = 0; c < 4; c++) begin
         rdy = a_in_ready;
         in_valid = (accepted < 4);
         in_pc = 64'h1000 + 64'(4 * accepted);
         step();
         if (rdy && in_valid) accepted++;
      end
      tests_run++;
      if (accepted != 2 || a_in_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL bp_stall got accepted=%0d in_ready=%b want 2/0", accepted, a_in_ready);
      end
      tests_run++;
      if (a_out_valid !== 1'b1 || a_out_pc !== 32'h1000 || b_out_pc !== 64'h1000) begin
         tests_failed++;
         $display("[TB] FAIL bp_hold got v=%b pc_a=%h pc_b=%h want 1/1000/1000", a_out_valid, a_out_pc, b_out_pc);
      end
      out_ready = 1'b1;
      #1;
      tests_run++;
      if (a_in_ready !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL bp_no_comb_ready got in_ready=%b want 0", a_in_ready);
      end
      for (int c = 0; c < 12 && delivered < 4; c++) begin
         if (a_out_valid && out_ready) begin
            got_pc[delivered] = a_out_pc;
            delivered++;
         end
         rdy = a_in_ready;
         in_valid = (accepted < 4);
         in_pc = 64'h1000 + 64'(4 * accepted);
         step();
         if (rdy && in_valid) accepted++;
      end
      in_valid = 1'b0;
      tests_run++;
      if (delivered != 4) begin
         tests_failed++;
         $display("[TB] FAIL bp_timeout got delivered=%0d want 4", delivered);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (got_pc[i] !== 32'h1000 + 32'(4 * i)) begin
            tests_failed++;
            $display("[TB] FAIL bp_order[%0d] got pc=%h want %h", i, got_pc[i], 32'h1000 + 32'(4 * i));
         end
      end
      tests_run++;
      if (a_out_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL bp_drain got out_valid=%b want 0", a_out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00000013;
      in_pc = 64'h2000;
      step();
      in_pc = 64'h2004;
      step();
      tests_run++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL flush_fill got in_ready=%b out_valid=%b want 0/1", a_in_ready, a_out_valid);
      end
      flush = 1'b1; in_pc = 64'h2008; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      tests_run++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL flush_clear got a v=%b r=%b b v=%b r=%b want 0/1", a_out_valid, a_in_ready,
                  b_out_valid, b_in_ready);
      end
      tests_run++;
      if (b_err_count !== 16'd6) begin
         tests_failed++;
         $display("[TB] FAIL flush_keeps_count got %0d want 6", b_err_count);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         tests_run++;
         if (a_out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_ghost[%0d] got out_valid=%b pc=%h want 0", c, a_out_valid, a_out_pc);
         end
      end
      in_valid = 1'b1; in_pc = 64'h200C;
      step();
      in_valid = 1'b0;
      tests_run++;
      if (a_out_valid !== 1'b1 || a_out_pc !== 32'h200C) begin
         tests_failed++;
         $display("[TB] FAIL flush_restart got v=%b pc=%h want 1/200c", a_out_valid, a_out_pc);
      end
      step();
   endtask

   task automatic test_saturation_reset();
      logic [1:0] exp_a;
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if (a_err_count !== 2'd0 || b_err_count !== 16'd0) begin
         tests_failed++;
         $display("[TB] FAIL sat_start got a=%0d b=%0d want 0/0", a_err_count, b_err_count);
      end
      out_ready = 1'b1; in_inst = 32'h00000000;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_pc = 64'h3000 + 64'(4 * i);
         step();
         exp_a = (i > 3) ? 2'd3 : 2'(i);
         tests_run++;
         if (a_err_count !== exp_a) begin
            tests_failed++;
            $display("[TB] FAIL sat_count[%0d] got %0d want %0d", i, a_err_count, exp_a);
         end
      end
      in_valid = 1'b0;
      step();
      tests_run++;
      if (a_err_count !== 2'd3 || b_err_count !== 16'd5) begin
         tests_failed++;
         $display("[TB] FAIL sat_final got a=%0d b=%0d want 3/5", a_err_count, b_err_count);
      end
      in_valid = 1'b1;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      tests_run++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_err_count !== 2'd0 || b_err_count !== 16'd0) begin
         tests_failed++;
         $display("[TB] FAIL mid_reset got v=%b r=%b a=%0d b=%0d want 0/1/0/0", a_out_valid, a_in_ready,
                  a_err_count, b_err_count);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_immediates();
      test_legality_basic();
      test_legality_table();
      test_backpressure();
      test_flush();
      test_saturation_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
Registered instruction-decode pipeline stage, the parametrised successor to the package-level RV32I field/immediate decode function. It sits between fetch and register-read/issue and accepts one 32-bit instruction plus PC per valid/ready beat. It emits the split fields, an XLEN-wide sign-extended immediate and a full legality check. The check covers RV32I/RV64I base and an optional M extension, and the stage supports flush plus a saturating illegal-instruction counter.

Parameters:
XLEN, 32, datapath width; 32 or 64 only, any other value is an elaboration error
ENABLE_M, 0, 1 = OP/OP-32 funct7=0x01 (M extension) is legal
ERR_CNT_WIDTH, 16, width of saturating illegal-instruction counter

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush  input  1  discard all buffered beats
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_inst  input  32  raw instruction
in_pc  input  XLEN  instruction PC
out_valid  output  1  decoded beat valid
out_ready  input  1  downstream accepts
out_pc  output  XLEN  PC of the decoded beat
out_opcode  output  7  inst[6:0]
out_rd  output  5  inst[11:7]
out_rs1  output  5  inst[19:15]
out_rs2  output  5  inst[24:20]
out_funct3  output  3  inst[14:12]
out_funct7  output  7  inst[31:25]
out_funct12  output  12  inst[31:20]
out_imm  output  XLEN  sign-extended immediate
out_decode_error  output  1  illegal instruction
err_count  output  ERR_CNT_WIDTH  illegal beats delivered, saturating

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, in_ready=1, err_count=0, both buffer entries empty. Data outputs are don't-care while out_valid=0.
- Clock and reset: single clock; reset is synchronous and active-high.
- Structure: decode is combinational from in_inst and is captured into a 2-entry skid buffer (main + skid). Latency is 1 cycle: a beat accepted at edge N is presented with out_valid=1 after edge N.
- Handshake: transfer occurs when valid&&ready.
  - in_ready is a register output: 1 iff the skid entry is empty. There is no combinational path from out_ready to in_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - Full throughput is 1 beat/cycle when out_ready=1 continuously.
  - Ordering is strictly FIFO.
- Flush: at an edge with flush=1, both entries are cleared, out_valid=0 and in_ready=1 next cycle, and a beat presented in the same cycle is dropped. Flush has priority over any accept or emit in that cycle. Rst has priority over flush.
- Immediate generation, sign bit inst[31] replicated to XLEN:
  - STORE: S-type.
  - LUI/AUIPC: U-type, low 12 bits zero.
  - JAL: J-type.
  - BRANCH: B-type.
  - All other opcodes: I-type.
- Legality: out_decode_error=1 if any of the following hold.
  - inst[1:0]!=2'b11.
  - Opcode is not one of 0x33, 0x13, 0x03, 0x23, 0x37, 0x17, 0x6F, 0x67, 0x63, 0x73, 0x0F, or (XLEN=64 only) 0x1B, 0x3B.
  - LOAD funct3 is 3/6/7 when XLEN=32; funct3=7 when XLEN=64.
  - STORE funct3>2 when XLEN=32; funct3>3 when XLEN=64.
  - BRANCH funct3 is 2 or 3.
  - JALR funct3!=0.
  - MISC_MEM funct3>1.
  - SYSTEM funct3=4, or funct3=0 with funct12 not in {0,1} or rd!=0 or rs1!=0.
  - OP: funct7 not in {0x00, 0x20, 0x01 if ENABLE_M}, or funct7=0x20 with funct3 not in {0,5}.
  - OP-IMM shifts: for SLLI, the upper immediate bits must be 0. For SRLI/SRAI, the upper immediate bits must be 0 or 0x20 (imm[11:5] when XLEN=32, imm[11:6]<<1 pattern when XLEN=64).
  - OP-IMM-32 (0x1B): funct3 not in {0,1,5}, or shift funct7 is illegal as for 32-bit.
  - OP-32 (0x3B): funct3 not in {0,1,5}, or funct7 illegal as for OP. With ENABLE_M, funct3 {0,4,5,6,7} is legal with funct7=0x01.
- Illegal beats are still delivered; no stall is taken.
- err_count increments by 1 on each output transfer with out_decode_error=1 and saturates at all-ones. It is not cleared by flush.

Test Plan:
- XLEN=32, in 0xFFF00093 (addi x1,x0,-1) -> one cycle later out_opcode=0x13, rd=1, rs1=0, imm=0xFFFFFFFF, error=0.
- XLEN=64, in 0xFFDFF06F (jal x0,-4) -> imm=0xFFFFFFFFFFFFFFFC; in 0x0000B083 (ld x1,0(x1)) -> error=0. The same 0x0000B083 with XLEN=32 -> error=1 and err_count=1.
- ENABLE_M=0, in 0x022081B3 (mul x3,x1,x2) -> error=1; with ENABLE_M=1 -> error=0. Also 0x00000000 -> error=1.
- Backpressure: 4 back-to-back beats with out_ready=0 -> in_ready drops after 2 beats accepted and outputs hold the first beat. Releasing out_ready delivers beats 1..4 in order, and in_ready never depends combinationally on out_ready.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and no dropped beat ever appears at the output.
- Saturation with ERR_CNT_WIDTH=2: 5 illegal beats -> err_count=3. Rst mid-stream -> out_valid=0 and err_count=0 on the next cycle.
